// File: rtl/usb_rx_bit_decoder_if.sv
// rtl/usb_rx_bit_decoder_if.sv - line-sample inputs and decoded-bit/byte outputs of the USB RX bit decoder
interface usb_rx_bit_decoder_if;
  logic       d_plus;
  logic       d_minus;
  logic       sample_en;
  logic       crc_bit;
  logic       crc_shift;
  logic       crc_clear;
  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       eop;
  logic       rx_error;

  modport master (
    output d_plus, d_minus, sample_en,
    input  crc_bit, crc_shift, crc_clear, rx_byte, byte_valid, eop, rx_error
  );

  modport slave (
    input  d_plus, d_minus, sample_en,
    output crc_bit, crc_shift, crc_clear, rx_byte, byte_valid, eop, rx_error
  );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// rtl/usb_rx_bit_decoder.sv - USB RX NRZI decode, SYNC detect, bit unstuffing and EOP detect
// Optional SE1 protocol-error detection enabled by defining RX_SE1_DETECT_EN.
module usb_rx_bit_decoder #(
  parameter logic [7:0] SYNC_BYTE   = 8'h80,
  parameter int         STUFF_LIMIT = 6
) (
  input logic                 clk,
  input logic                 n_rst,
  usb_rx_bit_decoder_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_EOP, S_ERROR} state_t;

  localparam logic [1:0] LN_J      = 2'd0;
  localparam logic [1:0] LN_K      = 2'd1;
  localparam logic [1:0] LN_SE0    = 2'd2;
  localparam logic [3:0] STUFF_LIM = 4'(STUFF_LIMIT);

  state_t     state_q, state_d;
  logic [1:0] prev_q, prev_d, line_c;
  logic [3:0] ones_q, ones_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sr_q, sr_d, byte_q, byte_d;
  logic [1:0] se0_q, se0_d;
  logic       crc_bit_q, crc_bit_d, shift_q, shift_d;
  logic       bv_q, bv_d, eop_q, eop_d, err_q, err_d;
  logic       dec_bit, se1, fault;

  // SE1 folds into J unless the detection option is built in
  assign line_c = (!bus.d_plus && !bus.d_minus) ? LN_SE0 :
                  (!bus.d_plus &&  bus.d_minus) ? LN_K   : LN_J;
`ifdef RX_SE1_DETECT_EN
  assign se1 = bus.d_plus & bus.d_minus;
`else
  assign se1 = 1'b0;
`endif
  assign dec_bit = (line_c == prev_q);

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    ones_d    = ones_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    byte_d    = byte_q;
    se0_d     = se0_q;
    crc_bit_d = crc_bit_q;
    shift_d   = 1'b0;
    bv_d      = 1'b0;
    eop_d     = 1'b0;
    err_d     = err_q;
    fault     = 1'b0;
    if (bus.sample_en) begin
      prev_d = line_c;
      case (state_q)
        S_IDLE: begin
          if (line_c == LN_K) begin
            state_d = S_SYNC;
            err_d   = 1'b0;
            sr_d    = {1'b0, sr_q[7:1]};
            bit_d   = 3'd1;
          end
        end
        S_SYNC: begin
          if (se1 || line_c == LN_SE0) begin
            fault = 1'b1;
          end else begin
            sr_d = {dec_bit, sr_q[7:1]};
            if (bit_q == 3'd7) begin
              if (sr_d == SYNC_BYTE) begin
                state_d = S_DATA;
                ones_d  = 4'd1;
                bit_d   = 3'd0;
              end else begin
                fault = 1'b1;
              end
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        S_DATA: begin
          if (se1) begin
            fault = 1'b1;
          end else if (line_c == LN_SE0) begin
            state_d = S_EOP;
            se0_d   = 2'd1;
          end else if (ones_q == STUFF_LIM) begin
            if (dec_bit) fault = 1'b1;
            else         ones_d = 4'd0;
          end else begin
            crc_bit_d = dec_bit;
            shift_d   = 1'b1;
            sr_d      = {dec_bit, sr_q[7:1]};
            ones_d    = dec_bit ? ones_q + 4'd1 : 4'd0;
            bit_d     = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              byte_d = sr_d;
              bv_d   = 1'b1;
            end
          end
        end
        S_EOP: begin
          if (se1 || line_c == LN_K) begin
            fault = 1'b1;
          end else if (line_c == LN_SE0) begin
            if (se0_q == 2'd2) fault = 1'b1;
            else               se0_d = 2'd2;
          end else if (se0_q == 2'd2) begin
            eop_d   = 1'b1;
            state_d = S_IDLE;
            if (bit_q != 3'd0) err_d = 1'b1;
          end else begin
            fault = 1'b1;
          end
        end
        default: begin
          if (line_c == LN_SE0)                  se0_d   = 2'd1;
          else if (line_c == LN_J && se0_q != 0) state_d = S_IDLE;
        end
      endcase
      // an SE0 that causes the error already counts toward leaving ERROR
      if (fault) begin
        err_d   = 1'b1;
        state_d = S_ERROR;
        se0_d   = (line_c == LN_SE0) ? 2'd1 : 2'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      prev_q    <= LN_J;
      ones_q    <= 4'd0;
      bit_q     <= 3'd0;
      sr_q      <= 8'h00;
      byte_q    <= 8'h00;
      se0_q     <= 2'd0;
      crc_bit_q <= 1'b0;
      shift_q   <= 1'b0;
      bv_q      <= 1'b0;
      eop_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      ones_q    <= ones_d;
      bit_q     <= bit_d;
      sr_q      <= sr_d;
      byte_q    <= byte_d;
      se0_q     <= se0_d;
      crc_bit_q <= crc_bit_d;
      shift_q   <= shift_d;
      bv_q      <= bv_d;
      eop_q     <= eop_d;
      err_q     <= err_d;
    end
  end

  assign bus.crc_bit    = crc_bit_q;
  assign bus.crc_shift  = shift_q;
  assign bus.crc_clear  = (state_q == S_IDLE) || (state_q == S_SYNC) || (state_q == S_ERROR);
  assign bus.rx_byte    = byte_q;
  assign bus.byte_valid = bv_q;
  assign bus.eop        = eop_q;
  assign bus.rx_error   = err_q;
endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// tb/tb_usb_rx_bit_decoder.sv - scoreboard bench for the USB RX bit decoder
module tb_usb_rx_bit_decoder;
  localparam int SYM_J = 0, SYM_K = 1, SYM_SE0 = 2;

  logic tb_clk = 1'b0;
  logic n_rst  = 1'b0;
  usb_rx_bit_decoder_if bus ();

  usb_rx_bit_decoder dut (.clk(tb_clk), .n_rst(n_rst), .bus(bus));

  always #5 tb_clk = ~tb_clk;

  int   n_vec = 0;
  int   n_bad = 0;
  bit   exp_bits[$];
  bit   got_bits[$];
  logic [7:0] exp_bytes[$];
  logic [7:0] got_bytes[$];
  int   eop_cnt = 0;
  bit   lvl = 1'b1;
  int   ones = 0;
  int   exp_pos = 0;
  logic [7:0] cur = 8'h00;

  always @(negedge tb_clk) begin
    if (bus.crc_shift)  got_bits.push_back(bus.crc_bit);
    if (bus.byte_valid) got_bytes.push_back(bus.rx_byte);
    if (bus.eop)        eop_cnt++;
  end

  task automatic send_sym(input int s);
    @(negedge tb_clk);
    case (s)
      SYM_J:   begin bus.d_plus = 1'b1; bus.d_minus = 1'b0; end
      SYM_K:   begin bus.d_plus = 1'b0; bus.d_minus = 1'b1; end
      default: begin bus.d_plus = 1'b0; bus.d_minus = 1'b0; end
    endcase
    bus.sample_en = 1'b1;
    @(negedge tb_clk);
    bus.sample_en = 1'b0;
    repeat (2) @(negedge tb_clk);
  endtask

  task automatic send_nrzi(input bit b);
    if (!b) lvl = ~lvl;
    send_sym(lvl ? SYM_J : SYM_K);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) send_sym(SYM_J);
    lvl = 1'b1;
  endtask

  task automatic send_sync();
    logic [7:0] s;
    s = 8'h80;
    for (int i = 0; i < 8; i++) send_nrzi(s[i]);
    ones = 1;
    exp_pos = 0;
  endtask

  task automatic send_data(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      send_nrzi(v[i]);
      exp_bits.push_back(v[i]);
      cur = {v[i], cur[7:1]};
      exp_pos++;
      if (exp_pos % 8 == 0) exp_bytes.push_back(cur);
      ones = v[i] ? ones + 1 : 0;
      if (ones == 6) begin
        send_nrzi(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    send_sym(SYM_SE0);
    send_sym(SYM_SE0);
    send_sym(SYM_J);
    lvl = 1'b1;
  endtask

  task automatic clear_sb();
    exp_bits.delete(); got_bits.delete();
    exp_bytes.delete(); got_bytes.delete();
    eop_cnt = 0;
  endtask

  task automatic test_reset();
    bus.d_plus = 1'b1; bus.d_minus = 1'b0; bus.sample_en = 1'b0;
    n_rst = 1'b0;
    repeat (3) @(negedge tb_clk);
    n_vec++; if (bus.crc_clear !== 1'b1) begin n_bad++; $display("FAIL reset_crc_clear got %b want 1", bus.crc_clear); end
    n_vec++; if (bus.crc_shift !== 1'b0) begin n_bad++; $display("FAIL reset_crc_shift got %b want 0", bus.crc_shift); end
    n_vec++; if (bus.crc_bit !== 1'b0) begin n_bad++; $display("FAIL reset_crc_bit got %b want 0", bus.crc_bit); end
    n_vec++; if (bus.rx_byte !== 8'h00) begin n_bad++; $display("FAIL reset_rx_byte got %h want 00", bus.rx_byte); end
    n_vec++; if (bus.byte_valid !== 1'b0 || bus.eop !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got bv=%b eop=%b want 0 0", bus.byte_valid, bus.eop); end
    n_vec++; if (bus.rx_error !== 1'b0) begin n_bad++; $display("FAIL reset_rx_error got %b want 0", bus.rx_error); end
    n_rst = 1'b1;
    send_idle(3);
    clear_sb();
  endtask

  task automatic test_basic();
    bit gb, eb;
    clear_sb();
    send_idle(2);
    send_sync();
    n_vec++; if (bus.crc_clear !== 1'b0) begin n_bad++; $display("FAIL basic_clear_in_data got %b want 0", bus.crc_clear); end
    send_data(16'h00A5, 8);
    send_eop();
    n_vec++; if (got_bits.size() != 8) begin n_bad++; $display("FAIL basic_nbits got %0d want 8", got_bits.size()); end
    while (got_bits.size() > 0 && exp_bits.size() > 0) begin
      gb = got_bits.pop_front(); eb = exp_bits.pop_front();
      n_vec++; if (gb !== eb) begin n_bad++; $display("FAIL basic_bit got %b want %b", gb, eb); end
    end
    n_vec++; if (got_bytes.size() != 1 || got_bytes[0] !== 8'hA5) begin n_bad++; $display("FAIL basic_byte got n=%0d b0=%h want 1 A5", got_bytes.size(), got_bytes.size() ? got_bytes[0] : 8'hxx); end
    n_vec++; if (eop_cnt != 1) begin n_bad++; $display("FAIL basic_eop got %0d want 1", eop_cnt); end
    n_vec++; if (bus.rx_error !== 1'b0) begin n_bad++; $display("FAIL basic_rx_error got %b want 0", bus.rx_error); end
    n_vec++; if (bus.crc_clear !== 1'b1) begin n_bad++; $display("FAIL basic_clear_idle got %b want 1", bus.crc_clear); end
  endtask

  task automatic test_stuffing();
    bit gb, eb;
    logic [7:0] gy, ey;
    clear_sb();
    send_idle(2);
    send_sync();
    send_data(16'h01FF, 16);
    send_eop();
    n_vec++; if (got_bits.size() != 16) begin n_bad++; $display("FAIL stuff_nbits got %0d want 16", got_bits.size()); end
    while (got_bits.size() > 0 && exp_bits.size() > 0) begin
      gb = got_bits.pop_front(); eb = exp_bits.pop_front();
      n_vec++; if (gb !== eb) begin n_bad++; $display("FAIL stuff_bit got %b want %b", gb, eb); end
    end
    n_vec++; if (got_bytes.size() != 2) begin n_bad++; $display("FAIL stuff_nbytes got %0d want 2", got_bytes.size()); end
    while (got_bytes.size() > 0 && exp_bytes.size() > 0) begin
      gy = got_bytes.pop_front(); ey = exp_bytes.pop_front();
      n_vec++; if (gy !== ey) begin n_bad++; $display("FAIL stuff_byte got %h want %h", gy, ey); end
    end
    n_vec++; if (eop_cnt != 1 || bus.rx_error !== 1'b0) begin n_bad++; $display("FAIL stuff_eop got eop=%0d err=%b want 1 0", eop_cnt, bus.rx_error); end
  endtask

  task automatic test_stuff_error();
    clear_sb();
    send_idle(2);
    send_sync();
    for (int i = 0; i < 7; i++) send_nrzi(1'b1);
    n_vec++; if (got_bits.size() != 5) begin n_bad++; $display("FAIL stufferr_nbits got %0d want 5", got_bits.size()); end
    n_vec++; if (bus.rx_error !== 1'b1) begin n_bad++; $display("FAIL stufferr_rx_error got %b want 1", bus.rx_error); end
    n_vec++; if (bus.crc_clear !== 1'b1) begin n_bad++; $display("FAIL stufferr_crc_clear got %b want 1", bus.crc_clear); end
    send_eop();
    n_vec++; if (eop_cnt != 0 || got_bits.size() != 5) begin n_bad++; $display("FAIL stufferr_after got eop=%0d nbits=%0d want 0 5", eop_cnt, got_bits.size()); end
    n_vec++; if (bus.rx_error !== 1'b1) begin n_bad++; $display("FAIL stufferr_sticky got %b want 1", bus.rx_error); end
  endtask

  task automatic test_bad_sync();
    int syms[8] = '{SYM_K, SYM_J, SYM_K, SYM_J, SYM_K, SYM_J, SYM_J, SYM_K};
    clear_sb();
    send_idle(2);
    for (int i = 0; i < 7; i++) send_sym(syms[i]);
    n_vec++; if (bus.rx_error !== 1'b0) begin n_bad++; $display("FAIL badsync_cleared got %b want 0", bus.rx_error); end
    send_sym(syms[7]);
    n_vec++; if (bus.rx_error !== 1'b1) begin n_bad++; $display("FAIL badsync_rx_error got %b want 1", bus.rx_error); end
    n_vec++; if (got_bits.size() != 0 || bus.crc_clear !== 1'b1) begin n_bad++; $display("FAIL badsync_quiet got nbits=%0d clr=%b want 0 1", got_bits.size(), bus.crc_clear); end
    send_sym(SYM_SE0);
    send_idle(2);
  endtask

  task automatic test_alignment();
    clear_sb();
    send_idle(2);
    send_sync();
    send_data(16'h053C, 12);
    send_eop();
    n_vec++; if (got_bits.size() != 12) begin n_bad++; $display("FAIL align_nbits got %0d want 12", got_bits.size()); end
    n_vec++; if (got_bytes.size() != 1 || got_bytes[0] !== exp_bytes[0]) begin n_bad++; $display("FAIL align_byte got n=%0d want 1 of %h", got_bytes.size(), exp_bytes[0]); end
    n_vec++; if (eop_cnt != 1 || bus.rx_error !== 1'b1) begin n_bad++; $display("FAIL align_eop_err got eop=%0d err=%b want 1 1", eop_cnt, bus.rx_error); end
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] gy, ey;
    clear_sb();
    send_idle(2);
    send_sync();
    send_data(16'h0005, 3);
    @(negedge tb_clk);
    n_rst = 1'b0;
    @(negedge tb_clk);
    n_vec++; if (bus.crc_clear !== 1'b1 || bus.crc_shift !== 1'b0 || bus.rx_error !== 1'b0) begin n_bad++; $display("FAIL midreset got clr=%b sh=%b err=%b want 1 0 0", bus.crc_clear, bus.crc_shift, bus.rx_error); end
    n_rst = 1'b1;
    clear_sb();
    send_idle(2);
    send_sync();
    send_data(16'h00A5, 8);
    send_eop();
    n_vec++; if (got_bytes.size() != 1) begin n_bad++; $display("FAIL midreset_nbytes got %0d want 1", got_bytes.size()); end
    while (got_bytes.size() > 0 && exp_bytes.size() > 0) begin
      gy = got_bytes.pop_front(); ey = exp_bytes.pop_front();
      n_vec++; if (gy !== ey) begin n_bad++; $display("FAIL midreset_byte got %h want %h", gy, ey); end
    end
    n_vec++; if (eop_cnt != 1 || bus.rx_error !== 1'b0) begin n_bad++; $display("FAIL midreset_eop got eop=%0d err=%b want 1 0", eop_cnt, bus.rx_error); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] gy, ey;
    clear_sb();
    send_idle(2);
    send_sync();
    send_data(16'h0012, 8);
    send_eop();
    send_sync();
    send_data(16'h00C3, 8);
    send_eop();
    n_vec++; if (got_bytes.size() != 2) begin n_bad++; $display("FAIL b2b_nbytes got %0d want 2", got_bytes.size()); end
    while (got_bytes.size() > 0 && exp_bytes.size() > 0) begin
      gy = got_bytes.pop_front(); ey = exp_bytes.pop_front();
      n_vec++; if (gy !== ey) begin n_bad++; $display("FAIL b2b_byte got %h want %h", gy, ey); end
    end
    n_vec++; if (eop_cnt != 2 || bus.rx_error !== 1'b0) begin n_bad++; $display("FAIL b2b_eop got eop=%0d err=%b want 2 0", eop_cnt, bus.rx_error); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuffing();
    test_stuff_error();
    test_bad_sync();
    test_alignment();
    test_reset_mid_data();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
